// File: rtl/rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter_if
//   Bundles the request/grant handshake between a set of requesters and the
//   round-robin arbiter that shares one resource among them.
//
//   Signals (L = number of requesters):
//     req        L            request vector, bit i = requester i
//     done       1            current grantee has finished with the resource
//     gnt        L            one-hot grant
//     gnt_idx    $clog2(L)    binary index of the grantee
//     gnt_valid  1            a grant is active
//     timeout    1            one-cycle pulse when the watchdog forced a release
//
//   Modports:
//     master  requester side: drives req/done, observes the grant
//     slave   arbiter side: observes req/done, drives the grant
// -----------------------------------------------------------------------------
interface rr_arbiter_if #(
  parameter int L = 4
);
  localparam int IW = $clog2(L);

  logic [L-1:0]  req;
  logic          done;
  logic [L-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter sharing one resource among L requesters. A rotating
//   priority encoder picks the next grantee starting from the requester after
//   the previous one; a two-state machine issues one registered grant at a
//   time and holds it until the grantee signals done or drops its request. A
//   watchdog forces release of a grant held for MAX_HOLD cycles (0 = no limit).
//   Every grant is followed by at least one idle cycle.
//
//   Ports:
//     clk   in   single clock, rising edge
//     rst   in   synchronous, active-high reset
//     bus   rr_arbiter_if.slave: req, done in; gnt, gnt_idx, gnt_valid,
//           timeout out (all outputs registered)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int L        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  rr_arbiter_if.slave bus
);

  localparam int IW = $clog2(L);
  // A zero-cycle limit still needs a one-bit counter to exist.
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(L - 1);
  localparam logic [CW-1:0] HOLD_SAT  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [L-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] hold_q, hold_d;

  // ---------------------------------------------------------------------------
  // Rotating-priority encoder: first set request at or above ptr, wrapping
  // L-1 -> 0. The modulo is done by subtraction so non-power-of-two L works.
  // ---------------------------------------------------------------------------
  logic [IW-1:0] winner;
  logic          found;

  always_comb begin
    int            pos;
    logic [IW-1:0] cand;
    winner = '0;
    found  = 1'b0;
    pos    = 0;
    cand   = '0;
    for (int k = 0; k < L; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= L) pos = pos - L;
      cand = IW'(pos);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Release conditions while BUSY.
  // ---------------------------------------------------------------------------
  logic rel_done, rel_drop, rel_hold, release_now;
  logic [IW-1:0] ptr_after;

  assign rel_done    = bus.done;
  assign rel_drop    = !bus.req[idx_q];
  assign rel_hold    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign release_now = rel_done || rel_drop || rel_hold;
  assign ptr_after   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default up front so no path through the
    // case leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (found) begin
          gnt_d[winner] = 1'b1;
          idx_d         = winner;
          valid_d       = 1'b1;
          hold_d        = '0;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          gnt_d     = '0;
          valid_d   = 1'b0;
          ptr_d     = ptr_after;
          state_d   = IDLE;
          // The pulse flags a watchdog release only when the grantee did not
          // also finish or withdraw on the same edge.
          timeout_d = rel_hold && !rel_done && !rel_drop;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers, synchronous reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
//   Directed self-checking bench for rr_arbiter. One instance with L=4,
//   MAX_HOLD=8 covers reset, rotation, watchdog, request drop and done/watchdog
//   collision; a second with L=3, MAX_HOLD=0 covers the non-power-of-two wrap
//   and the unlimited hold. Inputs change 1 ns after a rising edge, outputs are
//   checked at that same point.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rr_arbiter_if #(.L(4)) bus4 ();
  rr_arbiter_if #(.L(3)) bus3 ();

  rr_arbiter #(.L(4), .MAX_HOLD(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  rr_arbiter #(.L(3), .MAX_HOLD(0)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] g, input logic [1:0] idx,
                      input logic to);
    check({tag, ".gnt"},       32'(bus4.gnt),       32'(g));
    check({tag, ".gnt_idx"},   32'(bus4.gnt_idx),   32'(idx));
    check({tag, ".gnt_valid"}, 32'(bus4.gnt_valid), 32'(|g));
    check({tag, ".timeout"},   32'(bus4.timeout),   32'(to));
  endtask

  task automatic chk3(input string tag, input logic [2:0] g, input logic [1:0] idx,
                      input logic to);
    check({tag, ".gnt"},       32'(bus3.gnt),       32'(g));
    check({tag, ".gnt_idx"},   32'(bus3.gnt_idx),   32'(idx));
    check({tag, ".gnt_valid"}, 32'(bus3.gnt_valid), 32'(|g));
    check({tag, ".timeout"},   32'(bus3.timeout),   32'(to));
  endtask

  initial begin
    rst       = 1'b1;
    bus4.req  = 4'b1111;
    bus4.done = 1'b0;
    bus3.req  = 3'b000;
    bus3.done = 1'b0;

    // Reset held two cycles with all requests up: nothing granted.
    tick(); chk4("rst_c1", 4'b0000, 2'd0, 1'b0);
    tick(); chk4("rst_c2", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick(); chk4("first_gnt", 4'b0001, 2'd0, 1'b0);

    // Rotation 0,1,2,3,0 with done two cycles into each grant.
    for (int i = 0; i < 4; i++) begin
      int nx;
      nx = (i + 1) % 4;
      tick(); chk4("rot_hold", 4'(1 << i), 2'(i), 1'b0);
      bus4.done = 1'b1;
      tick(); chk4("rot_idle", 4'b0000, 2'(i), 1'b0);
      bus4.done = 1'b0;
      tick(); chk4("rot_next", 4'(1 << nx), 2'(nx), 1'b0);
    end

    // Grant 0 is active; dropping req[0] releases it, ptr -> 1.
    bus4.req = 4'b0100;
    tick(); chk4("drop0", 4'b0000, 2'd0, 1'b0);
    tick(); chk4("wd_g2", 4'b0100, 2'd2, 1'b0);
    for (int k = 1; k < 8; k++) begin
      tick(); chk4("wd_hold", 4'b0100, 2'd2, 1'b0);
    end
    tick(); chk4("wd_release", 4'b0000, 2'd2, 1'b1);
    tick(); chk4("wd_regrant", 4'b0100, 2'd2, 1'b0);

    // Request withdrawn: release, ptr -> 3; then grant 1 via wrap.
    bus4.req = 4'b0000;
    tick(); chk4("idle_empty", 4'b0000, 2'd2, 1'b0);
    bus4.req = 4'b0010;
    tick(); chk4("g1", 4'b0010, 2'd1, 1'b0);
    bus4.req = 4'b1001;
    tick(); chk4("drop1", 4'b0000, 2'd1, 1'b0);
    tick(); chk4("from2", 4'b1000, 2'd3, 1'b0);

    // done coinciding with the watchdog edge is a normal release.
    for (int k = 1; k < 8; k++) begin
      tick(); chk4("col_hold", 4'b1000, 2'd3, 1'b0);
    end
    bus4.done = 1'b1;
    tick(); chk4("col_release", 4'b0000, 2'd3, 1'b0);
    bus4.done = 1'b0;
    tick(); chk4("col_next", 4'b0001, 2'd0, 1'b0);

    // Reset during a grant drops it on that edge.
    rst = 1'b1;
    tick(); chk4("rst_mid", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick(); chk4("post_rst", 4'b0001, 2'd0, 1'b0);
    bus4.req = 4'b0000;
    tick(); chk4("post_rst_rel", 4'b0000, 2'd0, 1'b0);

    // L=3, no hold limit: grants 0,1,2,0 with done every 20 cycles.
    bus3.req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      int e;
      e = i % 3;
      tick(); chk3("l3_gnt", 3'(1 << e), 2'(e), 1'b0);
      for (int c = 1; c < 20; c++) begin
        tick();
        check("l3_hold.gnt",     32'(bus3.gnt),     32'(1 << e));
        check("l3_hold.timeout", 32'(bus3.timeout), 32'd0);
      end
      bus3.done = 1'b1;
      tick(); chk3("l3_release", 3'b000, 2'(e), 1'b0);
      bus3.done = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
